// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronizes/captures sources, arbitrates EI > T0 > T1,
// redirects the core at instruction boundaries and tracks handler call nesting.
module irq_ctrl #(
   parameter logic [9:0] VEC_EI      = 10'h010,
   parameter logic [9:0] VEC_T0      = 10'h020,
   parameter logic [9:0] VEC_T1      = 10'h030,
   parameter int         SYNC_STAGES = 2,
   parameter int         DEPTH_W     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       gie,
   input  logic [2:0] ie,
   input  logic       ext_int,
   input  logic       done_t0,
   input  logic       done_t1,
   input  logic       boundary,
   input  logic       call,
   input  logic       ret,
   input  logic       stack_full,
   output logic       irq_take,
   output logic [9:0] irq_vector,
   output logic [1:0] irq_source,
   output logic       done_ack_t0,
   output logic       done_ack_t1,
   output logic       overflow
);

   typedef enum logic [1:0] {IDLE, ACK, SERVICE} state_t;

   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_EI   = 2'd1;
   localparam logic [1:0] SRC_T0   = 2'd2;
   localparam logic [1:0] SRC_T1   = 2'd3;

   state_t               state, state_n;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                 ei_prev, ei_pend, ei_rise, ei_clr;
   logic [DEPTH_W-1:0]   depth, depth_n;
   logic [1:0]           src_n;
   logic [9:0]           vec_n;
   logic                 take_n, ack0_n, ack1_n, ovf_n;
   logic [2:0]           req;

   assign ei_rise = sync_q[SYNC_STAGES-1] & ~ei_prev;
   assign req     = {ei_pend, done_t0, done_t1} & ie;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         ei_prev <= 1'b0;
         ei_pend <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], ext_int};
         ei_prev <= sync_q[SYNC_STAGES-1];
         // a fresh edge wins over the clear caused by taking EI
         ei_pend <= ei_rise | (ei_pend & ~ei_clr);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         depth       <= '0;
         irq_take    <= 1'b0;
         irq_vector  <= '0;
         irq_source  <= SRC_NONE;
         done_ack_t0 <= 1'b0;
         done_ack_t1 <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         state       <= state_n;
         depth       <= depth_n;
         irq_take    <= take_n;
         irq_vector  <= vec_n;
         irq_source  <= src_n;
         done_ack_t0 <= ack0_n;
         done_ack_t1 <= ack1_n;
         overflow    <= ovf_n;
      end
   end

   always_comb begin
      state_n = state;
      depth_n = depth;
      src_n   = irq_source;
      vec_n   = irq_vector;
      take_n  = 1'b0;
      ack0_n  = done_ack_t0;
      ack1_n  = done_ack_t1;
      ovf_n   = overflow;
      ei_clr  = 1'b0;
      case (state)
         IDLE: begin
            if (boundary && gie && |req) begin
               if (stack_full) begin
                  ovf_n = 1'b1;
               end else begin
                  take_n  = 1'b1;
                  state_n = ACK;
                  if (req[2]) begin
                     src_n  = SRC_EI;
                     vec_n  = VEC_EI;
                     ei_clr = 1'b1;
                  end else if (req[1]) begin
                     src_n = SRC_T0;
                     vec_n = VEC_T0;
                  end else begin
                     src_n = SRC_T1;
                     vec_n = VEC_T1;
                  end
               end
            end
         end
         ACK: begin
            // ack rises one cycle after the take, falls once done reads low
            case (irq_source)
               SRC_T0: begin
                  if (!done_ack_t0) ack0_n = 1'b1;
                  else if (!done_t0) begin
                     ack0_n  = 1'b0;
                     state_n = SERVICE;
                  end
               end
               SRC_T1: begin
                  if (!done_ack_t1) ack1_n = 1'b1;
                  else if (!done_t1) begin
                     ack1_n  = 1'b0;
                     state_n = SERVICE;
                  end
               end
               default: state_n = SERVICE;
            endcase
         end
         SERVICE: begin
            if (call && !ret) begin
               if (depth == '1) ovf_n = 1'b1;
               else depth_n = depth + 1'b1;
            end else if (ret && !call) begin
               if (depth != '0) begin
                  depth_n = depth - 1'b1;
               end else begin
                  state_n = IDLE;
                  src_n   = SRC_NONE;
                  vec_n   = '0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: priority, masking, nesting, stack-full overflow,
// edges during service and asynchronous reset mid-service.
module tb_irq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       gie = 1'b0;
   logic [2:0] ie = 3'b000;
   logic       ext_int = 1'b0;
   logic       done_t0 = 1'b0;
   logic       done_t1 = 1'b0;
   logic       boundary = 1'b0;
   logic       call = 1'b0;
   logic       ret = 1'b0;
   logic       stack_full = 1'b0;
   logic       irq_take;
   logic [9:0] irq_vector;
   logic [1:0] irq_source;
   logic       done_ack_t0;
   logic       done_ack_t1;
   logic       overflow;

   int n_chk = 0;
   int n_pass = 0;

   irq_ctrl dut (
      .clk(clk), .rst(rst), .gie(gie), .ie(ie), .ext_int(ext_int),
      .done_t0(done_t0), .done_t1(done_t1), .boundary(boundary),
      .call(call), .ret(ret), .stack_full(stack_full),
      .irq_take(irq_take), .irq_vector(irq_vector), .irq_source(irq_source),
      .done_ack_t0(done_ack_t0), .done_ack_t1(done_ack_t1), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // advance one clock; outputs are sampled 1ns after the edge
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_boundary();
      boundary = 1'b1; tick(); boundary = 1'b0;
   endtask

   task automatic pulse_call();
      call = 1'b1; tick(); call = 1'b0;
   endtask

   task automatic pulse_ret();
      ret = 1'b1; tick(); ret = 1'b0;
   endtask

   task automatic check_take(input string tag, input logic [9:0] vec, input logic [1:0] src);
      check({tag, "_take"}, irq_take, 1);
      check({tag, "_vec"}, irq_vector, vec);
      check({tag, "_src"}, irq_source, src);
   endtask

   task automatic ext_edge();
      ext_int = 1'b0; tick(4);
      ext_int = 1'b1; tick(4);
   endtask

   initial begin
      tick(2);
      check("rst_take", irq_take, 0);
      check("rst_vec", irq_vector, 0);
      check("rst_src", irq_source, 0);
      check("rst_ack0", done_ack_t0, 0);
      check("rst_ack1", done_ack_t1, 0);
      check("rst_ovf", overflow, 0);
      rst = 1'b0;
      tick();

      // simultaneous EI + T0: EI first, then T0 with ack handshake
      gie = 1'b1; ie = 3'b111;
      ext_int = 1'b1; done_t0 = 1'b1;
      tick(4);
      pulse_boundary();
      check_take("sim_ei", 10'h010, 2'd1);
      tick();
      check("sim_ei_pulse", irq_take, 0);
      check("sim_ei_noack", done_ack_t0, 0);
      pulse_ret();
      check("sim_ei_end_src", irq_source, 0);
      check("sim_ei_end_vec", irq_vector, 0);
      pulse_boundary();
      check_take("sim_t0", 10'h020, 2'd2);
      check("sim_t0_ack_lag", done_ack_t0, 0);
      tick();
      check("sim_t0_ack_hi", done_ack_t0, 1);
      tick(2);
      check("sim_t0_ack_hold", done_ack_t0, 1);
      done_t0 = 1'b0;
      tick();
      check("sim_t0_ack_lo", done_ack_t0, 0);
      pulse_ret();
      check("sim_t0_end", irq_source, 0);

      // masking by gie
      gie = 1'b0; done_t1 = 1'b1;
      pulse_boundary();
      check("mask_no_take", irq_take, 0);
      check("mask_src", irq_source, 0);
      gie = 1'b1;
      pulse_boundary();
      check_take("mask_t1", 10'h030, 2'd3);
      tick();
      check("mask_ack1_hi", done_ack_t1, 1);
      done_t1 = 1'b0;
      tick();
      check("mask_ack1_lo", done_ack_t1, 0);
      pulse_ret();
      check("mask_end", irq_source, 0);

      // nested calls inside an EI handler
      ext_edge();
      pulse_boundary();
      check_take("nest", 10'h010, 2'd1);
      tick();
      pulse_call(); pulse_call(); pulse_ret(); pulse_ret();
      check("nest_src_held", irq_source, 1);
      check("nest_vec_held", irq_vector, 10'h010);
      pulse_ret();
      check("nest_end", irq_source, 0);
      check("nest_no_ovf", overflow, 0);

      // stack full blocks the take and sets overflow
      ext_edge();
      stack_full = 1'b1;
      pulse_boundary();
      check("sf_no_take", irq_take, 0);
      check("sf_ovf", overflow, 1);
      stack_full = 1'b0;
      pulse_boundary();
      check_take("sf_take", 10'h010, 2'd1);
      check("sf_ovf_sticky", overflow, 1);
      tick();

      // new EI edge during service waits for the handler to return
      ext_edge();
      pulse_boundary();
      check("svc_no_take", irq_take, 0);
      check("svc_src_held", irq_source, 1);
      pulse_ret();
      check("svc_end", irq_source, 0);
      pulse_boundary();
      check_take("svc_retake", 10'h010, 2'd1);
      tick();
      pulse_ret();
      ext_int = 1'b0;
      tick(4);

      // asynchronous reset mid-service with depth 2
      done_t0 = 1'b1;
      pulse_boundary();
      check_take("ar_t0", 10'h020, 2'd2);
      tick();
      done_t0 = 1'b0;
      tick();
      pulse_call(); pulse_call();
      check("ar_pre_src", irq_source, 2);
      #2 rst = 1'b1;
      #1;
      check("ar_src", irq_source, 0);
      check("ar_vec", irq_vector, 0);
      check("ar_ovf", overflow, 0);
      check("ar_ack0", done_ack_t0, 0);
      check("ar_take", irq_take, 0);
      tick();
      rst = 1'b0;
      done_t0 = 1'b1;
      pulse_boundary();
      check_take("ar_fresh", 10'h020, 2'd2);
      tick();
      done_t0 = 1'b0;
      tick(2);
      pulse_ret();
      check("ar_depth_clr", irq_source, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller for the 8-bit CPU core. It collects the external interrupt pin and the Timer 0 / Timer 1 done flags, then arbitrates by fixed priority. At an instruction boundary it tells the core to push the PC and redirect to a vector. It tracks the in-service interrupt, including call nesting inside the handler, so that only the handler's own return ends service.

## Interface

Parameters:
- VEC_EI, 10'h010, external interrupt vector
- VEC_T0, 10'h020, Timer 0 vector
- VEC_T1, 10'h030, Timer 1 vector
- SYNC_STAGES, 2, synchronizer depth for ext_int (≥2)
- DEPTH_W, 4, width of handler call-nesting counter

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- gie  in  1  global interrupt enable (cpu_cfg[7])
- ie  in  3  per-source enables: [2]=EI, [1]=T0, [0]=T1 (cpu_cfg[6:4])
- ext_int  in  1  asynchronous external interrupt pin
- done_t0  in  1  Timer 0 done, level
- done_t1  in  1  Timer 1 done, level
- boundary  in  1  one-cycle strobe: core is finishing EXECUTING and may be redirected
- call  in  1  one-cycle strobe: core executed a call (stack push)
- ret  in  1  one-cycle strobe: core executed a return (stack pop)
- stack_full  in  1  core stack is full
- irq_take  out  1  one-cycle pulse: core must push the PC and load irq_vector
- irq_vector  out  10  target vector, valid from irq_take until service ends
- irq_source  out  2  0 none, 1 EI, 2 T0, 3 T1; the in-service source
- done_ack_t0  out  1  Timer 0 done acknowledge
- done_ack_t1  out  1  Timer 1 done acknowledge
- overflow  out  1  sticky error flag; cleared only by rst

## Operation

Event capture:
- ext_int passes through a SYNC_STAGES flip-flop synchronizer.
- A rising edge of the synchronized signal sets ei_pend.
- ei_pend clears when EI is taken. If a new edge coincides with the clear, set wins.
- T0 and T1 requests are the done levels themselves; they are not latched.

Request and priority:
- Effective request: req = {ei_pend, done_t0, done_t1} & ie.
- Priority is fixed: EI > T0 > T1.

FSM states: IDLE, ACK, SERVICE.

IDLE:
- Take condition: boundary && gie && |req && !stack_full.
- On take: latch the winning source and its vector, pulse irq_take, go to ACK. If the winner is EI, clear ei_pend.
- If the take condition holds except that stack_full is high: set overflow, take nothing, stay in IDLE; the request remains pending.
- ret or call in IDLE: ignored, since these are ordinary program calls.

ACK:
- T0 source: hold done_ack_t0 high until done_t0 reads low, then go to SERVICE.
- T1 source: the same with done_ack_t1 / done_t1.
- EI source: go to SERVICE the next cycle.

SERVICE:
- irq_source and irq_vector are held; no new take, whatever the requests. Pending sources wait.
- call: depth increments. If depth is at its maximum (2^DEPTH_W−1), set overflow and saturate depth.
- ret with depth > 0: depth decrements.
- ret with depth == 0: end of handler. Next cycle: state IDLE, irq_source = 0, irq_vector = 0.
- call and ret in the same cycle: depth is unchanged.
- gie or ie deasserting during ACK or SERVICE has no effect on the interrupt in progress.

Reset, asserted at any time including mid-service:
- All outputs 0 (irq_take, irq_vector, irq_source, done_ack_t0/t1, overflow).
- State IDLE, ei_pend = 0, depth = 0, synchronizer cleared.

## Timing

- ext_int edge to ei_pend: SYNC_STAGES+1 cycles.
- boundary to irq_take: 1 cycle. irq_take is a registered, single-cycle pulse, and irq_source / irq_vector become valid in the same cycle.
- done_ack_tX rises in the cycle after irq_take and falls in the cycle after done_tX is sampled low. Minimum ACK duration is 1 cycle.
- Handler ret to irq_source = 0: 1 cycle. A pending request can be taken at the first boundary after return to IDLE.
- The core pushes the PC on irq_take and does not assert call for that push.

## Test plan

- Simultaneous requests. gie=1, ie=3'b111, ext_int edge and done_t0=1 both present at a boundary → irq_take with irq_vector=10'h010, irq_source=1. After the handler ret, the next boundary gives irq_vector=10'h020, irq_source=2, and done_ack_t0 stays high until done_t0 drops.
- Masking. gie=0 with done_t1=1 → no irq_take. Raise gie, pulse boundary → irq_take with vector 10'h030, done_ack_t1 pulse.
- Nested calls. In an EI handler: call, call, ret, ret → irq_source remains 1. A third ret → irq_source=0 one cycle later.
- Stack full. stack_full=1 with a pending enabled request at boundary → no irq_take and overflow=1. Deassert stack_full → taken at the next boundary; overflow stays 1.
- Edge during service. A second ext_int edge while EI is in SERVICE → no take. After the handler ret and the next boundary → EI is taken again.
- Async reset during SERVICE (T0 in service, depth=2) → all outputs 0 immediately. After reset release, the next boundary with done_t0=1 → a fresh take.
